// File: rtl/dmem_bus_resp.sv
// Line-fill responder between the data cache and the memory port: fetches a line as
// pipelined 64-bit beats, refetching it if a write snoop hits the block mid-fill.
`timescale 1ns/1ps
module dmem_bus_resp #(
  parameter int LINE    = 256,
  parameter int OFFS    = 5,
  parameter int BLK_LEN = 59
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BLK_LEN-1:0] b_addr_d,
  input  logic               b_rd_d,
  output logic [LINE-1:0]    b_rdata_d,
  output logic               b_dv_d,
  output logic [63:0]        m_addr,
  output logic               m_rd,
  input  logic               m_rdy,
  input  logic               m_rvalid,
  input  logic [63:0]        m_rdata,
  input  logic               s_wr,
  input  logic [63:0]        s_addr,
  output logic               inv,
  output logic [BLK_LEN-1:0] b_inv_addr_d
);

  localparam int BEATS = LINE / 64;
  localparam int BW    = $clog2(BEATS);
  localparam int CW    = BW + 1;
  localparam logic [CW-1:0] BEATS_C = CW'(BEATS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [BLK_LEN-1:0] blk_q, blk_d;
  logic [CW-1:0]      iss_cnt_q, iss_cnt_d;
  logic [CW-1:0]      rcv_cnt_q, rcv_cnt_d;
  logic               stale_q, stale_d;
  logic [LINE-1:0]    rdata_q, rdata_d;
  logic               inv_q, inv_d;
  logic [BLK_LEN-1:0] inv_addr_q, inv_addr_d;

  logic [BLK_LEN-1:0] snoop_blk;
  logic               m_rd_c;
  int                 slot;
  logic               unused_offs;

  assign snoop_blk   = s_addr[63:OFFS];
  assign unused_offs = ^s_addr[OFFS-1:0];
  assign m_rd_c      = (state_q == S_FILL) && (iss_cnt_q < BEATS_C);

  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    iss_cnt_d  = iss_cnt_q;
    rcv_cnt_d  = rcv_cnt_q;
    stale_d    = stale_q;
    rdata_d    = rdata_q;
    inv_d      = s_wr;
    inv_addr_d = snoop_blk;
    slot       = int'(rcv_cnt_q[BW-1:0]);

    case (state_q)
      S_IDLE: begin
        if (b_rd_d) begin
          blk_d     = b_addr_d;
          iss_cnt_d = '0;
          rcv_cnt_d = '0;
          stale_d   = s_wr && (snoop_blk == b_addr_d);
          state_d   = S_FILL;
        end
      end
      S_FILL: begin
        if (m_rd_c && m_rdy) iss_cnt_d = iss_cnt_q + 1'b1;
        if (s_wr && (snoop_blk == blk_q)) stale_d = 1'b1;
        if (m_rvalid && (rcv_cnt_q < BEATS_C)) begin
          rdata_d[slot*64 +: 64] = m_rdata;
          rcv_cnt_d              = rcv_cnt_q + 1'b1;
        end
        // Completion is judged on the incoming final beat, so a snoop landing
        // in that same cycle still forces the refetch.
        if (rcv_cnt_d == BEATS_C) begin
          if (stale_d) begin
            iss_cnt_d = '0;
            rcv_cnt_d = '0;
            stale_d   = 1'b0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      blk_q      <= '0;
      iss_cnt_q  <= '0;
      rcv_cnt_q  <= '0;
      stale_q    <= 1'b0;
      rdata_q    <= '0;
      inv_q      <= 1'b0;
      inv_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      iss_cnt_q  <= iss_cnt_d;
      rcv_cnt_q  <= rcv_cnt_d;
      stale_q    <= stale_d;
      rdata_q    <= rdata_d;
      inv_q      <= inv_d;
      inv_addr_q <= inv_addr_d;
    end
  end

  assign b_dv_d       = (state_q == S_DONE);
  assign b_rdata_d    = rdata_q;
  assign m_rd         = m_rd_c;
  assign m_addr       = {blk_q, iss_cnt_q[BW-1:0], 3'b000};
  assign inv          = inv_q;
  assign b_inv_addr_d = inv_addr_q;

endmodule

// File: tb/tb_dmem_bus_resp.sv
// Directed bench for dmem_bus_resp: a small in-order memory model answers beat reads,
// and the main sequence checks fills, backpressure, snoops, reset and back-to-back fills.
`timescale 1ns/1ps
module tb_dmem_bus_resp;

  logic          clk;
  logic          rst_n;
  logic [58:0]   b_addr_d;
  logic          b_rd_d;
  logic [255:0]  b_rdata_d;
  logic          b_dv_d;
  logic [63:0]   m_addr;
  logic          m_rd;
  logic          m_rdy;
  logic          m_rvalid;
  logic [63:0]   m_rdata;
  logic          s_wr;
  logic [63:0]   s_addr;
  logic          inv;
  logic [58:0]   b_inv_addr_d;

  int n_chk  = 0;
  int n_fail = 0;

  // memory model controls, written by the main sequence only while idle or mid-cycle
  logic [63:0] mem_base;
  int          mem_lat;
  int          rdy_mode;
  int          req_cnt;
  int          mcyc;
  int          due_q[$];
  logic [63:0] dat_q[$];
  logic [63:0] addr_log[$];

  dmem_bus_resp dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .b_addr_d     (b_addr_d),
    .b_rd_d       (b_rd_d),
    .b_rdata_d    (b_rdata_d),
    .b_dv_d       (b_dv_d),
    .m_addr       (m_addr),
    .m_rd         (m_rd),
    .m_rdy        (m_rdy),
    .m_rvalid     (m_rvalid),
    .m_rdata      (m_rdata),
    .s_wr         (s_wr),
    .s_addr       (s_addr),
    .inv          (inv),
    .b_inv_addr_d (b_inv_addr_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    m_rvalid = 1'b0;
    m_rdata  = '0;
    m_rdy    = 1'b0;
    mcyc     = 0;
    forever begin
      @(negedge clk);
      mcyc++;
      m_rdy = (rdy_mode == 0) ? 1'b1 : mcyc[0];
      if (!rst_n) begin
        due_q.delete();
        dat_q.delete();
        m_rvalid = 1'b0;
      end else begin
        if (due_q.size() > 0 && due_q[0] == mcyc) begin
          m_rvalid = 1'b1;
          m_rdata  = dat_q[0];
          void'(due_q.pop_front());
          void'(dat_q.pop_front());
        end else begin
          m_rvalid = 1'b0;
        end
        if (m_rd && m_rdy) begin
          due_q.push_back(mcyc + mem_lat);
          dat_q.push_back(mem_base + 64'(m_addr[4:3]));
          addr_log.push_back(m_addr);
          req_cnt++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] exp_line(input logic [63:0] base);
    logic [255:0] l;
    for (int k = 0; k < 4; k++) l[k*64 +: 64] = base + 64'(k);
    return l;
  endfunction

  task automatic run_fill(input int max_cyc, input bit drop, output int dv_at,
                          output int dv_n, output logic [255:0] line);
    dv_at = -1;
    dv_n  = 0;
    line  = '0;
    for (int n = 1; n <= max_cyc; n++) begin
      step();
      if (b_dv_d === 1'b1) begin
        if (dv_n == 0) begin
          dv_at = n;
          line  = b_rdata_d;
        end
        dv_n++;
        if (!drop) return;
        b_rd_d = 1'b0;
      end
    end
  endtask

  task automatic check_addrs(input string tag, input logic [63:0] first, input int n);
    logic [63:0] got;
    chk({tag, "_req_count"}, 256'(addr_log.size()), 256'(n));
    for (int i = 0; i < n; i++) begin
      got = (i < addr_log.size()) ? addr_log[i] : '1;
      chk($sformatf("%s_addr%0d", tag, i), 256'(got), 256'(first + 64'(8 * (i % 4))));
    end
  endtask

  task automatic new_test(input logic [63:0] base, input int lat, input int mode);
    mem_base = base;
    mem_lat  = lat;
    rdy_mode = mode;
    req_cnt  = 0;
    addr_log.delete();
  endtask

  int           dv_at;
  int           dv_n;
  logic [255:0] line;

  initial begin
    rst_n    = 1'b0;
    b_addr_d = '0;
    b_rd_d   = 1'b0;
    s_wr     = 1'b1;
    s_addr   = 64'h0000_0000_00AB_CDE0;
    new_test(64'h0, 1, 0);
    step();
    step();
    chk("rst_dv", 256'(b_dv_d), 256'(0));
    chk("rst_rdata", b_rdata_d, 256'(0));
    chk("rst_m_rd", 256'(m_rd), 256'(0));
    chk("rst_m_addr", 256'(m_addr), 256'(0));
    chk("rst_inv", 256'(inv), 256'(0));
    chk("rst_inv_addr", 256'(b_inv_addr_d), 256'(0));
    rst_n = 1'b1;
    s_wr  = 1'b0;
    step();

    // basic fill
    new_test(64'h1000_0000, 1, 0);
    b_addr_d = 59'h10;
    b_rd_d   = 1'b1;
    run_fill(10, 1'b1, dv_at, dv_n, line);
    chk("basic_dv_cycle", 256'(dv_at), 256'(6));
    chk("basic_dv_count", 256'(dv_n), 256'(1));
    chk("basic_line", line, exp_line(64'h1000_0000));
    chk("basic_hold", b_rdata_d, exp_line(64'h1000_0000));
    check_addrs("basic", 64'h200, 4);

    // backpressure with latency 3
    new_test(64'h5000_0000, 3, 1);
    b_addr_d = 59'h10;
    b_rd_d   = 1'b1;
    run_fill(40, 1'b1, dv_at, dv_n, line);
    chk("bp_dv_count", 256'(dv_n), 256'(1));
    chk("bp_line", line, exp_line(64'h5000_0000));
    check_addrs("bp", 64'h200, 4);

    // snoop hit at fill cycle 3: memory contents change with the write
    new_test(64'h2000_0000, 1, 0);
    b_addr_d = 59'h10;
    b_rd_d   = 1'b1;
    step();
    step();
    step();
    s_wr     = 1'b1;
    s_addr   = 64'h208;
    mem_base = 64'h3000_0000;
    step();
    chk("hit_inv", 256'(inv), 256'(1));
    chk("hit_inv_addr", 256'(b_inv_addr_d), 256'(59'h10));
    s_wr = 1'b0;
    step();
    chk("hit_inv_width", 256'(inv), 256'(0));
    chk("hit_no_early_dv", 256'(b_dv_d), 256'(0));
    run_fill(30, 1'b1, dv_at, dv_n, line);
    chk("hit_dv_count", 256'(dv_n), 256'(1));
    chk("hit_line", line, exp_line(64'h3000_0000));
    check_addrs("hit", 64'h200, 8);

    // snoop miss
    new_test(64'h4000_0000, 1, 0);
    b_addr_d = 59'h10;
    b_rd_d   = 1'b1;
    step();
    step();
    s_wr   = 1'b1;
    s_addr = 64'h400;
    step();
    chk("miss_inv", 256'(inv), 256'(1));
    chk("miss_inv_addr", 256'(b_inv_addr_d), 256'(59'h20));
    s_wr = 1'b0;
    run_fill(10, 1'b1, dv_at, dv_n, line);
    chk("miss_dv_cycle", 256'(dv_at), 256'(3));
    chk("miss_dv_count", 256'(dv_n), 256'(1));
    chk("miss_line", line, exp_line(64'h4000_0000));
    check_addrs("miss", 64'h200, 4);

    // reset mid-fill
    new_test(64'h6000_0000, 1, 0);
    b_addr_d = 59'h10;
    b_rd_d   = 1'b1;
    step();
    step();
    step();
    rst_n  = 1'b0;
    s_wr   = 1'b1;
    s_addr = 64'h999;
    step();
    chk("midrst_dv", 256'(b_dv_d), 256'(0));
    chk("midrst_m_rd", 256'(m_rd), 256'(0));
    chk("midrst_inv", 256'(inv), 256'(0));
    chk("midrst_state", 256'(dut.state_q), 256'(0));
    chk("midrst_rdata", b_rdata_d, 256'(0));
    rst_n  = 1'b1;
    s_wr   = 1'b0;
    b_rd_d = 1'b0;
    step();
    new_test(64'h8000_0000, 1, 0);
    b_addr_d = 59'h12;
    b_rd_d   = 1'b1;
    run_fill(10, 1'b1, dv_at, dv_n, line);
    chk("postrst_dv_cycle", 256'(dv_at), 256'(6));
    chk("postrst_line", line, exp_line(64'h8000_0000));
    check_addrs("postrst", 64'h240, 4);

    // back-to-back fills
    new_test(64'h7000_0000, 1, 0);
    b_addr_d = 59'h10;
    b_rd_d   = 1'b1;
    run_fill(10, 1'b0, dv_at, dv_n, line);
    chk("b2b_first_dv_cycle", 256'(dv_at), 256'(6));
    chk("b2b_first_line", line, exp_line(64'h7000_0000));
    b_addr_d = 59'h11;
    step();
    chk("b2b_gap_no_dv", 256'(b_dv_d), 256'(0));
    new_test(64'h7100_0000, 1, 0);
    run_fill(10, 1'b1, dv_at, dv_n, line);
    chk("b2b_second_dv_cycle", 256'(dv_at), 256'(6));
    chk("b2b_second_dv_count", 256'(dv_n), 256'(1));
    chk("b2b_second_line", line, exp_line(64'h7100_0000));
    check_addrs("b2b", 64'h220, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
